// File: rtl/fm_guard_receiver.sv
// fm_guard_receiver
//   Sink end of the write-back interface. One command covers one layer's output
//   plane. The receiver takes an 8-bit feature-map byte stream and a 6-bit guard
//   stream, each with its own valid/ready handshake. It packs each stream into
//   words and writes them to the FM SRAM and the guard SRAM. A single done pulse
//   follows once both streams are complete and every partial word is written.
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   start                               command pulse, sampled only in IDLE
//   pace_i, guard_num_i                 element counts for the command
//   fm_base_i, guard_base_i             first word address of each SRAM
//   data_i/data_i_valid/fm_buf_ready    FM byte stream
//   guard_i/guard_i_valid/guard_buf_ready  guard stream
//   fm_wr_en/fm_wr_addr/fm_wr_data      FM SRAM write port
//   guard_wr_en/guard_wr_addr/guard_wr_data  guard SRAM write port
//   busy, done                          command status

// fm_guard_packer
//   Per-stream element counter, lane packer and SRAM write register. It is
//   instantiated once for the FM stream and once for the guard stream.
// Ports
//   load_i latches limit_i/base_i; active_i enables the handshake;
//   reached_o shows that the element count equals the limit; wr_*_o is the
//   registered SRAM write.
module fm_guard_packer #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            active_i,
    input  logic [15:0]     limit_i,
    input  logic [AW-1:0]   base_i,
    input  logic [W-1:0]    elem_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic            reached_o,
    output logic            wr_en_o,
    output logic [AW-1:0]   wr_addr_o,
    output logic [N*W-1:0]  wr_data_o
);
    logic [15:0]           limit_q, cnt_q;
    logic [LW-1:0]         lane_q;
    logic [N-1:0][W-1:0]   pack_q, word_d;
    logic [AW-1:0]         ptr_q, wr_addr_q;
    logic [N*W-1:0]        wr_data_q;
    logic                  wr_en_q;
    logic                  take, flush;

    assign ready_o   = active_i && (cnt_q < limit_q);
    assign reached_o = (cnt_q == limit_q);
    assign take      = ready_o && valid_i;
    // take implies limit_q >= 1, so limit_q - 1 cannot underflow here.
    assign flush     = take && ((lane_q == LW'(N - 1)) || (cnt_q == limit_q - 16'd1));

    // Lanes above the current one are still zero, because the pack register is
    // cleared on every flush. A short final word is therefore zero-padded.
    always_comb begin
        word_d         = pack_q;
        word_d[lane_q] = elem_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_q   <= '0;
            cnt_q     <= '0;
            lane_q    <= '0;
            pack_q    <= '0;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            wr_en_q <= flush;
            if (load_i) begin
                limit_q <= limit_i;
                cnt_q   <= '0;
                lane_q  <= '0;
                pack_q  <= '0;
                ptr_q   <= base_i;
            end else if (take) begin
                cnt_q <= cnt_q + 16'd1;
                if (flush) begin
                    lane_q    <= '0;
                    pack_q    <= '0;
                    wr_data_q <= word_d;
                    wr_addr_q <= ptr_q;
                    ptr_q     <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
                end else begin
                    lane_q <= lane_q + LW'(1);
                    pack_q <= word_d;
                end
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
endmodule

module fm_guard_receiver #(
    parameter int FM_WORD_BYTES  = 4,
    parameter int GUARD_PER_WORD = 4,
    parameter int FM_DEPTH       = 1024,
    parameter int GUARD_DEPTH    = 1024,
    localparam int FAW           = $clog2(FM_DEPTH),
    localparam int GAW           = $clog2(GUARD_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [15:0]                   pace_i,
    input  logic [15:0]                   guard_num_i,
    input  logic [FAW-1:0]                fm_base_i,
    input  logic [GAW-1:0]                guard_base_i,
    input  logic [7:0]                    data_i,
    input  logic                          data_i_valid,
    output logic                          fm_buf_ready,
    input  logic [5:0]                    guard_i,
    input  logic                          guard_i_valid,
    output logic                          guard_buf_ready,
    output logic                          fm_wr_en,
    output logic [FAW-1:0]                fm_wr_addr,
    output logic [8*FM_WORD_BYTES-1:0]    fm_wr_data,
    output logic                          guard_wr_en,
    output logic [GAW-1:0]                guard_wr_addr,
    output logic [6*GUARD_PER_WORD-1:0]   guard_wr_data,
    output logic                          busy,
    output logic                          done
);
    typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;
    state_e state_q, state_d;
    logic   load, active, fm_reached, g_reached;

    assign load   = (state_q == IDLE) && start;
    assign active = (state_q == RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Each packer raises its write strobe on the same edge at which its count
    // reaches the limit. Leaving RECV once both counts are reached therefore
    // places DONE in the cycle after the final write pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RECV;
            RECV:    if (fm_reached && g_reached) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    fm_guard_packer #(.W(8), .N(FM_WORD_BYTES), .DEPTH(FM_DEPTH)) u_fm (
        .clk(clk), .rst_n(rst_n), .load_i(load), .active_i(active),
        .limit_i(pace_i), .base_i(fm_base_i), .elem_i(data_i), .valid_i(data_i_valid),
        .ready_o(fm_buf_ready), .reached_o(fm_reached), .wr_en_o(fm_wr_en),
        .wr_addr_o(fm_wr_addr), .wr_data_o(fm_wr_data)
    );

    fm_guard_packer #(.W(6), .N(GUARD_PER_WORD), .DEPTH(GUARD_DEPTH)) u_guard (
        .clk(clk), .rst_n(rst_n), .load_i(load), .active_i(active),
        .limit_i(guard_num_i), .base_i(guard_base_i), .elem_i(guard_i), .valid_i(guard_i_valid),
        .ready_o(guard_buf_ready), .reached_o(g_reached), .wr_en_o(guard_wr_en),
        .wr_addr_o(guard_wr_addr), .wr_data_o(guard_wr_data)
    );
endmodule

// File: tb/tb_fm_guard_receiver.sv
// Testbench for fm_guard_receiver: table-driven commands, randomized commands,
// a reset during a command and start pulses during RECV. Writes are predicted
// from the streamed element lists by chunking them into words.
module tb_fm_guard_receiver;
    localparam int FWB = 4, GPW = 4, FD = 1024, GD = 1024;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] pace_i = '0, guard_num_i = '0;
    logic [9:0]  fm_base_i = '0, guard_base_i = '0;
    logic [7:0]  data_i = '0;
    logic        data_i_valid = 1'b0, fm_buf_ready;
    logic [5:0]  guard_i = '0;
    logic        guard_i_valid = 1'b0, guard_buf_ready;
    logic        fm_wr_en, guard_wr_en, busy, done;
    logic [9:0]  fm_wr_addr, guard_wr_addr;
    logic [31:0] fm_wr_data;
    logic [23:0] guard_wr_data;

    fm_guard_receiver dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pace_i(pace_i), .guard_num_i(guard_num_i),
        .fm_base_i(fm_base_i), .guard_base_i(guard_base_i),
        .data_i(data_i), .data_i_valid(data_i_valid), .fm_buf_ready(fm_buf_ready),
        .guard_i(guard_i), .guard_i_valid(guard_i_valid), .guard_buf_ready(guard_buf_ready),
        .fm_wr_en(fm_wr_en), .fm_wr_addr(fm_wr_addr), .fm_wr_data(fm_wr_data),
        .guard_wr_en(guard_wr_en), .guard_wr_addr(guard_wr_addr), .guard_wr_data(guard_wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int fm_wr_tot = 0, g_wr_tot = 0, done_tot = 0;

    always @(negedge clk) begin
        if (fm_wr_en)    fm_wr_tot++;
        if (guard_wr_en) g_wr_tot++;
        if (done)        done_tot++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Word k of a stream: elements k*per .. k*per+per-1, first one in the LSBs,
    // with zeros for any position beyond the end of the stream.
    function automatic logic [63:0] word_of(input int q[$], input int k, input int per, input int bits);
        logic [63:0] w = '0;
        for (int j = 0; j < per; j++)
            if (k * per + j < q.size())
                w |= 64'(q[k * per + j]) << (bits * j);
        return w;
    endfunction

    task automatic chk_wr(input string nm, input bit ex, input logic en, input logic [63:0] addr,
                          input logic [63:0] data, input int q[$], input int cnt, input int per,
                          input int bits, input int base, input int depth,
                          inout int n, inout int la);
        int k;
        chk({nm, "_wr_en"}, 64'(en), 64'(ex));
        if (ex) begin
            k = (cnt - 1) / per;
            chk({nm, "_wr_addr"}, addr, 64'((base + k) % depth));
            chk({nm, "_wr_data"}, data, word_of(q, k, per, bits));
        end
        if (en) begin
            n++;
            la = int'(addr);
        end
    endtask

    // Runs one command. mode: 0 = valid every cycle, 1 = alternating, 2 = random.
    // glitch: iteration at which a bogus start is pulsed during RECV (-1 = none).
    // Returns the number of write pulses seen and the last address written.
    task automatic run_cmd(input int pace, input int gnum, input int fb, input int gb,
                           input int mode, input int glitch,
                           output int nfw, output int ngw, output int lfa, output int lga);
        int fq[$], gq[$];
        int fi, gi, it, dn0, fw0, gw0, limit;
        bit ef, eg, vf, vg;
        for (int i = 0; i < pace; i++) fq.push_back(int'($urandom_range(0, 255)));
        for (int i = 0; i < gnum; i++) gq.push_back(int'($urandom_range(0, 63)));
        nfw = 0; ngw = 0; lfa = -1; lga = -1;
        dn0 = done_tot; fw0 = fm_wr_tot; gw0 = g_wr_tot;
        pace_i = 16'(pace); guard_num_i = 16'(gnum);
        fm_base_i = 10'(fb); guard_base_i = 10'(gb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble the command inputs to show that they were latched.
        pace_i = 16'($urandom); guard_num_i = 16'($urandom);
        fm_base_i = 10'($urandom); guard_base_i = 10'($urandom);
        fi = 0; gi = 0; it = 0; ef = 0; eg = 0;
        limit = 4 * (pace + gnum) + 100;
        while ((fi < pace || gi < gnum) && it < limit) begin
            chk_wr("fm", ef, fm_wr_en, 64'(fm_wr_addr), 64'(fm_wr_data), fq, fi, FWB, 8, fb, FD, nfw, lfa);
            chk_wr("guard", eg, guard_wr_en, 64'(guard_wr_addr), 64'(guard_wr_data), gq, gi, GPW, 6, gb, GD, ngw, lga);
            chk("fm_buf_ready", 64'(fm_buf_ready), 64'(fi < pace));
            chk("guard_buf_ready", 64'(guard_buf_ready), 64'(gi < gnum));
            chk("busy_recv", 64'(busy), 64'(1));
            vf = (mode == 0) ? 1'b1 : (mode == 1) ? (it % 2 == 0) : 1'($urandom_range(0, 1));
            vg = (mode == 0) ? 1'b1 : (mode == 1) ? (it % 2 == 1) : 1'($urandom_range(0, 1));
            data_i_valid = vf; guard_i_valid = vg;
            data_i  = (fi < pace) ? 8'(fq[fi]) : 8'($urandom);
            guard_i = (gi < gnum) ? 6'(gq[gi]) : 6'($urandom);
            if (it == glitch) begin
                start = 1'b1; pace_i = 16'd3; guard_num_i = 16'd1;
                fm_base_i = 10'd500; guard_base_i = 10'd500;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            it++;
            ef = vf && (fi < pace);
            if (ef) fi++;
            ef = ef && ((fi % FWB == 0) || (fi == pace));
            eg = vg && (gi < gnum);
            if (eg) gi++;
            eg = eg && ((gi % GPW == 0) || (gi == gnum));
        end
        start = 1'b0;
        if (it >= limit) chk("stream_timeout", 64'(1), 64'(0));
        chk_wr("fm", ef, fm_wr_en, 64'(fm_wr_addr), 64'(fm_wr_data), fq, fi, FWB, 8, fb, FD, nfw, lfa);
        chk_wr("guard", eg, guard_wr_en, 64'(guard_wr_addr), 64'(guard_wr_data), gq, gi, GPW, 6, gb, GD, ngw, lga);
        chk("fm_ready_end", 64'(fm_buf_ready), 64'(0));
        chk("guard_ready_end", 64'(guard_buf_ready), 64'(0));
        chk("done_early", 64'(done), 64'(0));
        // Extra valid beats after the final element must not be accepted.
        data_i_valid = 1'b1; guard_i_valid = 1'b1;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_done", 64'(busy), 64'(1));
        chk("fm_wr_in_done", 64'(fm_wr_en), 64'(0));
        chk("guard_wr_in_done", 64'(guard_wr_en), 64'(0));
        @(negedge clk);
        chk("done_after", 64'(done), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("fm_ready_idle", 64'(fm_buf_ready), 64'(0));
        data_i_valid = 1'b0; guard_i_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_count", 64'(done_tot - dn0), 64'(1));
        chk("fm_wr_count", 64'(fm_wr_tot - fw0), 64'((pace + FWB - 1) / FWB));
        chk("guard_wr_count", 64'(g_wr_tot - gw0), 64'((gnum + GPW - 1) / GPW));
    endtask

    typedef struct {
        int pace, gnum, fb, gb, mode, glitch;
        int exp_nfw, exp_ngw, exp_lfa, exp_lga;
    } vec_t;

    vec_t vt[7];
    int nfw, ngw, lfa, lga;
    int p, g, fb, gb;
    int fw0, dn0;

    initial begin
        //        pace   gnum fb    gb    mode glitch  nfw    ngw lfa   lga
        vt[0] = '{8,     6,   0,    0,    0,  -1,     2,     2,  1,    1};
        vt[1] = '{5,     0,   0,    0,    1,  -1,     2,     0,  1,   -1};
        vt[2] = '{12,    3,   1023, 5,    0,  -1,     3,     1,  1,    5};
        vt[3] = '{0,     0,   40,   40,   0,  -1,     0,     0, -1,   -1};
        vt[4] = '{10,    9,   100,  1022, 2,   3,     3,     3,  102,  0};
        vt[5] = '{4,     4,   7,    7,    0,   1,     1,     1,  7,    7};
        vt[6] = '{65535, 0,   0,    0,    0,  -1,     16384, 0,  1023, -1};

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_fm_ready", 64'(fm_buf_ready), 64'(0));
        chk("rst_fm_wr", 64'({fm_wr_en, fm_wr_addr, fm_wr_data}), 64'(0));
        chk("rst_guard_wr", 64'({guard_wr_en, guard_wr_addr, guard_wr_data}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_cmd(vt[i].pace, vt[i].gnum, vt[i].fb, vt[i].gb, vt[i].mode, vt[i].glitch,
                    nfw, ngw, lfa, lga);
            chk($sformatf("vec%0d_nfw", i), 64'(nfw), 64'(vt[i].exp_nfw));
            chk($sformatf("vec%0d_ngw", i), 64'(ngw), 64'(vt[i].exp_ngw));
            chk($sformatf("vec%0d_lfa", i), 64'(lfa), 64'(vt[i].exp_lfa));
            chk($sformatf("vec%0d_lga", i), 64'(lga), 64'(vt[i].exp_lga));
        end

        for (int r = 0; r < 10; r++) begin
            p  = int'($urandom_range(0, 40));
            g  = int'($urandom_range(0, 30));
            fb = int'($urandom_range(0, FD - 1));
            gb = int'($urandom_range(0, GD - 1));
            run_cmd(p, g, fb, gb, int'($urandom_range(0, 2)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1,
                    nfw, ngw, lfa, lga);
            chk("rnd_nfw", 64'(nfw), 64'((p + FWB - 1) / FWB));
            chk("rnd_ngw", 64'(ngw), 64'((g + GPW - 1) / GPW));
            chk("rnd_lfa", 64'(lfa), (p == 0) ? 64'(-1) : 64'((fb + (p + FWB - 1) / FWB - 1) % FD));
            chk("rnd_lga", 64'(lga), (g == 0) ? 64'(-1) : 64'((gb + (g + GPW - 1) / GPW - 1) % GD));
        end

        // Reset after 3 of 8 bytes: everything drops at once and nothing follows.
        pace_i = 16'd8; guard_num_i = 16'd4; fm_base_i = 10'd0; guard_base_i = 10'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_i_valid = 1'b1; data_i = 8'hA5; guard_i_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        fw0 = fm_wr_tot; dn0 = done_tot;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_ready", 64'({fm_buf_ready, guard_buf_ready}), 64'(0));
        chk("mid_rst_fm_wr", 64'({fm_wr_en, fm_wr_addr, fm_wr_data}), 64'(0));
        chk("mid_rst_guard_wr", 64'({guard_wr_en, guard_wr_addr, guard_wr_data}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        data_i_valid = 1'b0;
        chk("post_rst_no_write", 64'(fm_wr_tot - fw0), 64'(0));
        chk("post_rst_no_done", 64'(done_tot - dn0), 64'(0));
        chk("post_rst_idle", 64'({busy, fm_buf_ready}), 64'(0));
        run_cmd(8, 6, 20, 30, 0, 2, nfw, ngw, lfa, lga);
        chk("post_rst_nfw", 64'(nfw), 64'(2));
        chk("post_rst_lfa", 64'(lfa), 64'(21));
        chk("post_rst_lga", 64'(lga), 64'(31));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end
endmodule
